uart_rx_packer: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_receiver.sv | 159 +++++++++++++++
 rtl/uart_rx_packer.sv | 95 +++++++++
 tb/tb_uart_rx_packer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional build macro RX_PARITY_EN adds the PARITY state used by the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 87;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
`ifdef RX_PARITY_EN
        ,
        PARITY  = 3'd5
`endif
    } rx_state_t;

endpackage

// File: rtl/uart_receiver.sv
// 8N1 UART receiver (8E1 when RX_PARITY_EN is defined): 2-FF input synchroniser,
// mid-bit sampling FSM, and one-cycle byte/frame-error/parity-error strobes.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_serial_in,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      byte_done,
    output logic                      frame_err,
`ifdef RX_PARITY_EN
    output logic                      parity_err,
`endif
    output logic                      byte_strobe,
    output logic [UART_DATA_BITS-1:0] byte_val
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

    rx_state_t                 state_q, state_d;
    logic                      sync1_q, rx_s_q;
    logic [CW-1:0]             clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                      byte_done_q, byte_done_d;
    logic                      frame_err_q, frame_err_d;
    logic                      bit_end, stop_sample, frame_strobe;
`ifdef RX_PARITY_EN
    logic                      parity_err_q, parity_err_d;
    logic                      par_bad_q, par_bad_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else begin
            sync1_q     <= rx_serial_in;
            rx_s_q      <= sync1_q;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
`ifdef RX_PARITY_EN
            parity_err_q <= parity_err_d;
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + CW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        byte_done_d = byte_strobe;
        frame_err_d = frame_strobe;
`ifdef RX_PARITY_EN
        parity_err_d = 1'b0;
        par_bad_d    = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                // Re-check the line at the middle of the start bit to reject glitches.
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
`ifdef RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == BIT_LAST) begin
`ifdef RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    clk_cnt_d    = '0;
                    state_d      = STOP;
                    par_bad_d    = ^{shift_q, rx_s_q};
                    parity_err_d = ^{shift_q, rx_s_q};
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = CLEANUP;
                end
            end
            CLEANUP: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
        if (byte_strobe) rx_byte_d = shift_q;
    end

    always_comb begin
        bit_end      = (clk_cnt_q == CNT_LAST);
        stop_sample  = (state_q == STOP) && bit_end;
        byte_strobe  = stop_sample && rx_s_q;
`ifdef RX_PARITY_EN
        byte_strobe  = stop_sample && rx_s_q && !par_bad_q;
        parity_err   = parity_err_q;
`endif
        frame_strobe = stop_sample && !rx_s_q;
        byte_val     = shift_q;
        rx_byte      = rx_byte_q;
        byte_done    = byte_done_q;
        frame_err    = frame_err_q;
    end

endmodule

// File: rtl/uart_rx_packer.sv
// Packs received UART bytes into BYTES_PER_WORD-byte words behind a valid/ready handshake.
// Optional build macro RX_PARITY_EN enables even-parity checking and the parity_err port.
module uart_rx_packer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
    parameter int BYTES_PER_WORD = 32
) (
    input  logic                                 uart_clk,
    input  logic                                 i_rst,
    input  logic                                 rx_serial_in,
    input  logic                                 word_ready,
    output logic                                 word_valid,
    output logic [UART_DATA_BITS*BYTES_PER_WORD-1:0] word_data,
    output logic [UART_DATA_BITS-1:0]            rx_byte,
    output logic                                 byte_done,
    output logic                                 frame_err,
`ifdef RX_PARITY_EN
    output logic                                 parity_err,
`endif
    output logic                                 overflow_o
);

    localparam int WORD_W = UART_DATA_BITS * BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    logic                      byte_strobe;
    logic [UART_DATA_BITS-1:0] byte_val;
    logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]         asm_q, asm_d;
    logic [WORD_W-1:0]         word_data_q, word_data_d;
    logic                      word_valid_q, word_valid_d;
    logic                      overflow_q, overflow_d;

    uart_receiver #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (uart_clk),
        .rst         (i_rst),
        .rx_serial_in(rx_serial_in),
        .rx_byte     (rx_byte),
        .byte_done   (byte_done),
        .frame_err   (frame_err),
`ifdef RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .byte_strobe (byte_strobe),
        .byte_val    (byte_val)
    );

    always_ff @(posedge uart_clk) begin
        if (i_rst) begin
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q && !word_ready;
        overflow_d   = overflow_q;
        if (byte_strobe) begin
            asm_d[{byte_cnt_q, 3'b000} +: UART_DATA_BITS] = byte_val;
            if (byte_cnt_q == LAST_BYTE) begin
                byte_cnt_d = '0;
                // A completed word may replace the held one only if it leaves this cycle.
                if (!word_valid_q || word_ready) begin
                    word_data_d  = asm_d;
                    word_valid_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Bench for uart_rx_packer at CLKS_PER_BIT=4: vector table, corner sequences and
// randomized frames checked against a queue-based model of the byte/word stream.
module tb_uart_rx_packer;

    localparam int CPB = 4;
    localparam int BPW = 32;

    logic         uart_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         rx_serial_in = 1'b1;
    logic         word_ready = 1'b0;
    logic         word_valid;
    logic [255:0] word_data;
    logic [7:0]   rx_byte;
    logic         byte_done;
    logic         frame_err;
    logic         overflow_o;
`ifdef RX_PARITY_EN
    logic         parity_err;
`endif

    uart_rx_packer #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(BPW)) dut (
        .uart_clk    (uart_clk),
        .i_rst       (i_rst),
        .rx_serial_in(rx_serial_in),
        .word_ready  (word_ready),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .rx_byte     (rx_byte),
        .byte_done   (byte_done),
        .frame_err   (frame_err),
`ifdef RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .overflow_o  (overflow_o)
    );

    always #5 uart_clk = ~uart_clk;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   got_bytes[$];
    logic [255:0] got_words[$];
    int           ferr_cnt = 0;
    int           perr_cnt = 0;
    int           mcnt = 0;
    bit           chk_clear = 0;
    bit           prev_hold = 0;
    logic [255:0] prev_data = '0;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_done;
        logic       exp_ferr;
    } vec_t;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge uart_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_ok);
        rx_serial_in = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial_in = b[i];
            step(CPB);
        end
`ifdef RX_PARITY_EN
        rx_serial_in = (^b) ^ ~par_ok;
        step(CPB);
`endif
        rx_serial_in = stop_bit;
        step(CPB);
        rx_serial_in = 1'b1;
        step(4);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step(3);
        i_rst = 1'b0;
        step(1);
        got_bytes.delete();
        got_words.delete();
    endtask

    function automatic logic [255:0] pack(input logic [7:0] q[$]);
        logic [255:0] r = '0;
        for (int k = 0; k < q.size() && k < BPW; k++) r[8*k +: 8] = q[k];
        return r;
    endfunction

    // Observer: collects the byte/word stream and checks handshake timing rules.
    always @(negedge uart_clk) begin
        if (i_rst) begin
            mcnt      = 0;
            chk_clear = 0;
            prev_hold = 0;
        end else begin
            if (chk_clear) begin
                check("wv_clear", word_valid, 1'b0);
                chk_clear = 0;
            end
            if (prev_hold) check("hold", word_data, prev_data);
            if (byte_done) begin
                got_bytes.push_back(rx_byte);
                mcnt++;
                if (mcnt == BPW) begin
                    mcnt = 0;
                    check("wv_latency", word_valid, 1'b1);
                    chk_clear = word_ready;
                end
            end
            if (frame_err) ferr_cnt++;
`ifdef RX_PARITY_EN
            if (parity_err) perr_cnt++;
`endif
            if (word_valid && word_ready) got_words.push_back(word_data);
            prev_hold = word_valid && !word_ready;
            prev_data = word_data;
        end
    end

    initial begin
        vec_t         vecs[6];
        logic [7:0]   last_good;
        logic [7:0]   q[$];
        logic [7:0]   b;
        logic         s;
        int           d0, f0, p0, nbad;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h77, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h55, 1'b0, 1'b0, 1'b1};

        // Reset state
        step(3);
        @(negedge uart_clk);
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_word_data", word_data, '0);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_byte_done", byte_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overflow", overflow_o, 1'b0);
        @(posedge uart_clk);
        #1;
        i_rst = 1'b0;
        step(2);

        // Table of single frames
        last_good = 8'h00;
        foreach (vecs[i]) begin
            d0 = got_bytes.size();
            f0 = ferr_cnt;
            send_byte(vecs[i].data, vecs[i].stop_bit, 1'b1);
            step(2);
            if (vecs[i].exp_done) last_good = vecs[i].data;
            check($sformatf("vec%0d_done", i), got_bytes.size() - d0, vecs[i].exp_done);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_rx_byte", i), rx_byte, last_good);
        end
        check("table_word_valid", word_valid, 1'b0);

        // One-cycle glitch must not start a frame
        d0 = got_bytes.size();
        f0 = ferr_cnt;
        rx_serial_in = 1'b0;
        step(1);
        rx_serial_in = 1'b1;
        step(20);
        check("glitch_done", got_bytes.size() - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        send_byte(8'h77, 1'b1, 1'b1);
        step(2);
        check("post_glitch_rx_byte", rx_byte, 8'h77);

        // Full word 0x00..0x1F with ready high
        do_reset();
        word_ready = 1'b1;
        q.delete();
        for (int k = 0; k < BPW; k++) begin
            q.push_back(8'(k));
            send_byte(8'(k), 1'b1, 1'b1);
        end
        step(4);
        check("word_count", got_words.size(), 1);
        if (got_words.size() > 0) check("word_data_seq", got_words[0], pack(q));
        check("word_valid_after", word_valid, 1'b0);
        check("no_overflow", overflow_o, 1'b0);

        // Two random words with ready low: second dropped, first held
        do_reset();
        word_ready = 1'b0;
        q.delete();
        for (int k = 0; k < BPW; k++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_byte(b, 1'b1, 1'b1);
        end
        step(2);
        check("ovf_first_valid", word_valid, 1'b1);
        check("ovf_first_data", word_data, pack(q));
        check("ovf_not_yet", overflow_o, 1'b0);
        for (int k = 0; k < BPW; k++) send_byte(8'($urandom), 1'b1, 1'b1);
        step(2);
        check("ovf_set", overflow_o, 1'b1);
        check("ovf_still_valid", word_valid, 1'b1);
        check("ovf_held_data", word_data, pack(q));
        check("ovf_no_transfer", got_words.size(), 0);
        word_ready = 1'b1;
        step(5);
        check("ovf_one_transfer", got_words.size(), 1);
        if (got_words.size() > 0) check("ovf_xfer_data", got_words[0], pack(q));
        check("ovf_valid_drop", word_valid, 1'b0);
        check("ovf_sticky", overflow_o, 1'b1);

        // Reset in the middle of byte 5's data bits, then realign with random frame errors
        do_reset();
        word_ready = 1'b1;
        for (int k = 0; k < 5; k++) send_byte(8'($urandom), 1'b1, 1'b1);
        rx_serial_in = 1'b0;
        step(CPB);
        for (int i = 0; i < 3; i++) begin
            rx_serial_in = 1'($urandom);
            step(CPB);
        end
        i_rst = 1'b1;
        step(2);
        @(negedge uart_clk);
        check("midrst_rx_byte", rx_byte, 8'h00);
        check("midrst_byte_done", byte_done, 1'b0);
        check("midrst_word_valid", word_valid, 1'b0);
        check("midrst_word_data", word_data, '0);
        check("midrst_overflow", overflow_o, 1'b0);
        @(posedge uart_clk);
        #1;
        rx_serial_in = 1'b1;
        i_rst = 1'b0;
        step(4);
        got_bytes.delete();
        got_words.delete();
        q.delete();
        nbad = 0;
        f0 = ferr_cnt;
        while (q.size() < BPW) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 7) != 0);
            send_byte(b, s, 1'b1);
            if (s) q.push_back(b);
            else nbad++;
        end
        step(4);
        check("realign_bytes", got_bytes.size(), BPW);
        check("realign_ferr", ferr_cnt - f0, nbad);
        check("realign_words", got_words.size(), 1);
        if (got_words.size() > 0) check("realign_data", got_words[0], pack(q));

`ifdef RX_PARITY_EN
        // Even parity: 0x01 needs parity bit 1
        d0 = got_bytes.size();
        p0 = perr_cnt;
        send_byte(8'h01, 1'b1, 1'b0);
        step(2);
        check("par_bad_perr", perr_cnt - p0, 1);
        check("par_bad_done", got_bytes.size() - d0, 0);
        send_byte(8'h01, 1'b1, 1'b1);
        step(2);
        check("par_ok_done", got_bytes.size() - d0, 1);
        check("par_ok_rx_byte", rx_byte, 8'h01);
        check("par_ok_perr", perr_cnt - p0, 1);
`else
        p0 = perr_cnt;
        check("no_parity_errs", perr_cnt, p0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
